// File: rtl/siso_arbiter.sv
// siso_arbiter
// Shares a single Siso soft-in/soft-out engine between NUM_REQ decoder
// requesters. An idle arbiter picks the next requester round-robin, latches
// that requester's sys/enc/ext operands, launches the engine with a one-cycle
// read_en pulse, waits for finish under a watchdog, then returns the LLR
// result with a one-cycle done pulse to the owner (plus err on timeout).
//
// Ports
//   clk_p_i         clock, rising edge
//   reset_n_i       asynchronous active-low reset
//   req_i           level request per requester
//   sys_i / enc_i   flattened sys/enc operands, requester r at [r*SYS_W +: SYS_W]
//   ext_i           flattened ext operands, requester r at [r*EXT_W +: EXT_W]
//   grant_o         one-hot current owner, zero when idle
//   done_o          one-cycle completion pulse to the owner
//   err_o           one-cycle pulse with done_o when the watchdog aborted
//   data_o          last successful engine result
//   busy_o          high whenever a job is in flight
//   siso_read_en_o  one-cycle launch pulse to the engine
//   siso_sys_o / siso_enc_o / siso_ext_o  latched operands to the engine
//   siso_data_i     engine result
//   siso_finish_i   engine completion strobe
module siso_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int SYS_W   = 28,
    parameter int EXT_W   = 70,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk_p_i,
    input  logic                     reset_n_i,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*SYS_W-1:0] sys_i,
    input  logic [NUM_REQ*SYS_W-1:0] enc_i,
    input  logic [NUM_REQ*EXT_W-1:0] ext_i,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic [NUM_REQ-1:0]       done_o,
    output logic                     err_o,
    output logic [EXT_W-1:0]         data_o,
    output logic                     busy_o,
    output logic                     siso_read_en_o,
    output logic [SYS_W-1:0]         siso_sys_o,
    output logic [SYS_W-1:0]         siso_enc_o,
    output logic [EXT_W-1:0]         siso_ext_o,
    input  logic [EXT_W-1:0]         siso_data_i,
    input  logic                     siso_finish_i
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);
    localparam logic [PTR_W-1:0] LAST_REQ  = PTR_W'(NUM_REQ - 1);
    localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RETURN = 2'd3
    } state_t;

    state_t               state_q;
    logic [PTR_W-1:0]     ptr_q;
    logic [PTR_W-1:0]     own_q;
    logic [WD_W-1:0]      wd_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [NUM_REQ-1:0]   done_q;
    logic                 err_q;
    logic                 read_en_q;
    logic [EXT_W-1:0]     data_q;
    logic [SYS_W-1:0]     sys_q;
    logic [SYS_W-1:0]     enc_q;
    logic [EXT_W-1:0]     ext_q;

    // Round-robin pick: rotate the request vector so the pointer lands at
    // bit 0, take the lowest set bit, then map the offset back to an index.
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [PTR_W-1:0]     off;
    logic [PTR_W:0]       sum;
    logic [PTR_W-1:0]     win;
    logic [NUM_REQ-1:0]   win_oh;
    logic [SYS_W-1:0]     win_sys;
    logic [SYS_W-1:0]     win_enc;
    logic [EXT_W-1:0]     win_ext;

    assign req_dbl = {req_i, req_i} >> ptr_q;

    always_comb begin
        req_rot = req_dbl[NUM_REQ-1:0];
        off     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) off = PTR_W'(k);
        end
        sum = {1'b0, ptr_q} + {1'b0, off};
        if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
        win     = sum[PTR_W-1:0];
        win_oh  = '0;
        win_sys = '0;
        win_enc = '0;
        win_ext = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (win == PTR_W'(r)) begin
                win_oh[r] = 1'b1;
                win_sys   = sys_i[r*SYS_W +: SYS_W];
                win_enc   = enc_i[r*SYS_W +: SYS_W];
                win_ext   = ext_i[r*EXT_W +: EXT_W];
            end
        end
    end

    always_ff @(posedge clk_p_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            own_q     <= '0;
            wd_q      <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            read_en_q <= 1'b0;
            data_q    <= '0;
            sys_q     <= '0;
            enc_q     <= '0;
            ext_q     <= '0;
        end else begin
            // Pulse outputs default low; each state raises them for one cycle.
            read_en_q <= 1'b0;
            done_q    <= '0;
            err_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|req_i) begin
                        grant_q   <= win_oh;
                        own_q     <= win;
                        sys_q     <= win_sys;
                        enc_q     <= win_enc;
                        ext_q     <= win_ext;
                        read_en_q <= 1'b1;
                        state_q   <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    wd_q    <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    wd_q <= wd_q + 1'b1;
                    // Finish is tested first so it wins over a same-cycle timeout.
                    if (siso_finish_i) begin
                        data_q  <= siso_data_i;
                        done_q  <= grant_q;
                        state_q <= ST_RETURN;
                    end else if (wd_q == WD_LIMIT) begin
                        done_q  <= grant_q;
                        err_q   <= 1'b1;
                        state_q <= ST_RETURN;
                    end
                end
                ST_RETURN: begin
                    grant_q <= '0;
                    ptr_q   <= (own_q == LAST_REQ) ? '0 : own_q + 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign grant_o        = grant_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign data_o         = data_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign siso_read_en_o = read_en_q;
    assign siso_sys_o     = sys_q;
    assign siso_enc_o     = enc_q;
    assign siso_ext_o     = ext_q;

endmodule

// File: tb/tb_siso_arbiter.sv
// Testbench for siso_arbiter: directed scenarios followed by randomized jobs,
// checked against a transaction-level reference (round-robin pick, expected
// done cycle, error flag and result).
module tb_siso_arbiter;

    localparam int NUM_REQ = 2;
    localparam int SYS_W   = 28;
    localparam int EXT_W   = 70;
    localparam int TIMEOUT = 8;

    logic                     clk_p_i = 1'b0;
    logic                     reset_n_i;
    logic [NUM_REQ-1:0]       req_i;
    logic [NUM_REQ*SYS_W-1:0] sys_i;
    logic [NUM_REQ*SYS_W-1:0] enc_i;
    logic [NUM_REQ*EXT_W-1:0] ext_i;
    logic [NUM_REQ-1:0]       grant_o;
    logic [NUM_REQ-1:0]       done_o;
    logic                     err_o;
    logic [EXT_W-1:0]         data_o;
    logic                     busy_o;
    logic                     siso_read_en_o;
    logic [SYS_W-1:0]         siso_sys_o;
    logic [SYS_W-1:0]         siso_enc_o;
    logic [EXT_W-1:0]         siso_ext_o;
    logic [EXT_W-1:0]         siso_data_i;
    logic                     siso_finish_i;

    siso_arbiter #(
        .NUM_REQ(NUM_REQ),
        .SYS_W  (SYS_W),
        .EXT_W  (EXT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_p_i       (clk_p_i),
        .reset_n_i     (reset_n_i),
        .req_i         (req_i),
        .sys_i         (sys_i),
        .enc_i         (enc_i),
        .ext_i         (ext_i),
        .grant_o       (grant_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .data_o        (data_o),
        .busy_o        (busy_o),
        .siso_read_en_o(siso_read_en_o),
        .siso_sys_o    (siso_sys_o),
        .siso_enc_o    (siso_enc_o),
        .siso_ext_o    (siso_ext_o),
        .siso_data_i   (siso_data_i),
        .siso_finish_i (siso_finish_i)
    );

    always #5 clk_p_i = ~clk_p_i;

    int checks = 0;
    int errors = 0;

    // Reference state: round-robin pointer and last good result.
    int               ptr_m  = 0;
    logic [EXT_W-1:0] data_m = '0;
    logic [SYS_W-1:0] exp_sys = '0;
    logic [SYS_W-1:0] exp_enc = '0;
    logic [EXT_W-1:0] exp_ext = '0;

    task automatic chk(input string tag, input logic [EXT_W-1:0] obs, input logic [EXT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_p_i);
        #1;
    endtask

    function automatic logic [EXT_W-1:0] rnd_ext();
        return EXT_W'({$urandom, $urandom, $urandom});
    endfunction

    function automatic logic [SYS_W-1:0] rnd_sys();
        return SYS_W'($urandom);
    endfunction

    // First set request scanning upward from p with wrap-around.
    function automatic int pick(input logic [NUM_REQ-1:0] r, input int p);
        logic [NUM_REQ-1:0] t;
        for (int i = 0; i < NUM_REQ; i++) begin
            t = r >> ((p + i) % NUM_REQ);
            if (t[0]) return (p + i) % NUM_REQ;
        end
        return 0;
    endfunction

    task automatic scramble_inputs();
        for (int r = 0; r < NUM_REQ; r++) begin
            sys_i[r*SYS_W +: SYS_W] = rnd_sys();
            enc_i[r*SYS_W +: SYS_W] = rnd_sys();
            ext_i[r*EXT_W +: EXT_W] = rnd_ext();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"},   EXT_W'(grant_o), '0);
        chk({tag, "_done"},    EXT_W'(done_o), '0);
        chk({tag, "_err"},     EXT_W'(err_o), '0);
        chk({tag, "_data"},    data_o, '0);
        chk({tag, "_busy"},    EXT_W'(busy_o), '0);
        chk({tag, "_read_en"}, EXT_W'(siso_read_en_o), '0);
        chk({tag, "_sys"},     EXT_W'(siso_sys_o), '0);
        chk({tag, "_enc"},     EXT_W'(siso_enc_o), '0);
        chk({tag, "_ext"},     siso_ext_o, '0);
    endtask

    // Idle cycles with no request and a stray finish strobe.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            req_i         = '0;
            siso_finish_i = 1'($urandom_range(0, 1));
            siso_data_i   = rnd_ext();
            tick();
            chk("idle_busy",  EXT_W'(busy_o), '0);
            chk("idle_grant", EXT_W'(grant_o), '0);
            chk("idle_done",  EXT_W'(done_o), '0);
            chk("idle_rden",  EXT_W'(siso_read_en_o), '0);
            chk("idle_data",  data_o, data_m);
        end
        siso_finish_i = 1'b0;
    endtask

    // One job starting in an IDLE cycle. j is the WAIT-cycle index (0 = first
    // cycle after read_en) where finish is raised; j >= TIMEOUT means never.
    task automatic do_job(input logic [NUM_REQ-1:0] req, input int j,
                          input logic [SYS_W-1:0] sys_w, input logic [EXT_W-1:0] res);
        int                 w;
        int                 last;
        bit                 ok;
        logic [NUM_REQ-1:0] oh;
        w  = pick(req, ptr_m);
        oh = NUM_REQ'(1) << w;
        ok = (j < TIMEOUT);
        last = ok ? j : TIMEOUT - 1;

        scramble_inputs();
        sys_i[w*SYS_W +: SYS_W] = sys_w;
        exp_sys = sys_w;
        exp_enc = enc_i[w*SYS_W +: SYS_W];
        exp_ext = ext_i[w*EXT_W +: EXT_W];
        req_i         = req;
        siso_finish_i = 1'($urandom_range(0, 1));
        siso_data_i   = rnd_ext();

        tick();  // launch cycle
        chk("launch_grant", EXT_W'(grant_o), EXT_W'(oh));
        chk("launch_rden",  EXT_W'(siso_read_en_o), EXT_W'(1'b1));
        chk("launch_busy",  EXT_W'(busy_o), EXT_W'(1'b1));
        chk("launch_done",  EXT_W'(done_o), '0);
        chk("launch_sys",   EXT_W'(siso_sys_o), EXT_W'(exp_sys));
        chk("launch_enc",   EXT_W'(siso_enc_o), EXT_W'(exp_enc));
        chk("launch_ext",   siso_ext_o, exp_ext);
        scramble_inputs();
        req_i         = NUM_REQ'($urandom);
        siso_finish_i = 1'($urandom_range(0, 1));

        for (int n = 0; n <= last; n++) begin
            tick();  // wait cycle n
            chk("wait_rden",  EXT_W'(siso_read_en_o), '0);
            chk("wait_done",  EXT_W'(done_o), '0);
            chk("wait_busy",  EXT_W'(busy_o), EXT_W'(1'b1));
            chk("wait_grant", EXT_W'(grant_o), EXT_W'(oh));
            chk("wait_data",  data_o, data_m);
            chk("wait_sys",   EXT_W'(siso_sys_o), EXT_W'(exp_sys));
            siso_finish_i = (n == j);
            siso_data_i   = (n == j) ? res : rnd_ext();
            scramble_inputs();
            req_i = NUM_REQ'($urandom);
        end

        tick();  // return cycle
        chk("ret_done",  EXT_W'(done_o), EXT_W'(oh));
        chk("ret_err",   EXT_W'(err_o), EXT_W'(ok ? 1'b0 : 1'b1));
        chk("ret_data",  data_o, ok ? res : data_m);
        chk("ret_grant", EXT_W'(grant_o), EXT_W'(oh));
        chk("ret_busy",  EXT_W'(busy_o), EXT_W'(1'b1));
        chk("ret_ext",   siso_ext_o, exp_ext);
        if (ok) data_m = res;
        ptr_m = (w + 1) % NUM_REQ;
        req_i         = '0;
        siso_finish_i = 1'($urandom_range(0, 1));
        siso_data_i   = rnd_ext();

        tick();  // back in idle
        chk("end_done",  EXT_W'(done_o), '0);
        chk("end_err",   EXT_W'(err_o), '0);
        chk("end_grant", EXT_W'(grant_o), '0);
        chk("end_busy",  EXT_W'(busy_o), '0);
        chk("end_data",  data_o, data_m);
        chk("end_sys",   EXT_W'(siso_sys_o), EXT_W'(exp_sys));
        chk("end_enc",   EXT_W'(siso_enc_o), EXT_W'(exp_enc));
        siso_finish_i = 1'b0;
    endtask

    initial begin
        reset_n_i     = 1'b0;
        req_i         = '0;
        sys_i         = '0;
        enc_i         = '0;
        ext_i         = '0;
        siso_data_i   = '0;
        siso_finish_i = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        reset_n_i = 1'b1;
        idle_cycles(2);

        // Contention: both held, latency 3 after read_en -> 01,10,01,10.
        for (int i = 0; i < 4; i++) do_job(2'b11, 2, rnd_sys(), rnd_ext());

        // Single request, finish 5 cycles after read_en.
        do_job(2'b01, 4, 28'h1234567, 70'h2A5);
        chk("single_data", data_o, 70'h2A5);

        // Timeout abort, then a normal job.
        do_job(2'b10, TIMEOUT + 3, rnd_sys(), rnd_ext());
        chk("timeout_keeps_data", data_o, 70'h2A5);
        do_job(2'b11, 0, rnd_sys(), rnd_ext());

        // Finish on the very last watchdog cycle counts as success.
        do_job(2'b01, TIMEOUT - 1, rnd_sys(), 70'h3_1415_9265_3589_7932);

        // Stray finish while idle, request dropped before being served.
        idle_cycles(4);

        // Reset during WAIT after leaving the pointer at 1.
        do_job(2'b01, 1, rnd_sys(), rnd_ext());
        scramble_inputs();
        req_i = 2'b01;
        tick();
        tick();
        tick();
        reset_n_i = 1'b0;
        #1;
        chk_all_zero("midreset");
        tick();
        tick();
        chk_all_zero("inreset");
        reset_n_i = 1'b1;
        req_i     = '0;
        ptr_m     = 0;
        data_m    = '0;
        tick();
        chk("postreset_done", EXT_W'(done_o), '0);
        chk("postreset_busy", EXT_W'(busy_o), '0);
        do_job(2'b11, 3, rnd_sys(), rnd_ext());
        do_job(2'b10, 2, rnd_sys(), rnd_ext());

        // Randomized jobs against the reference.
        for (int i = 0; i < 150; i++) begin
            int j;
            if ($urandom_range(0, 5) == 0) j = TIMEOUT + int'($urandom_range(0, 3));
            else j = int'($urandom_range(0, TIMEOUT - 1));
            do_job(NUM_REQ'($urandom_range(1, 3)), j, rnd_sys(), rnd_ext());
            if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
